// File: rtl/digit_reader.sv
// digit_reader: scans the 15 blocks of a renderer glyph and decodes the bitmap back to its index.
// Build option: DIGIT_READER_COLON_EN adds the colon glyph (index 10) to the match table.
module digit_reader #(
  parameter int LIT_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] x_block,
  output logic [2:0] y_block,
  input  logic       lit,
  output logic       busy,
  output logic       valid,
  output logic [3:0] number,
  output logic       unknown
);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, MATCH = 2'd3;
`ifdef DIGIT_READER_COLON_EN
  localparam int N_GLYPH = 11;
`else
  localparam int N_GLYPH = 10;
`endif
  // each glyph is {row4,...,row0}; within a row, bit x is column x
  localparam logic [10:0][14:0] GLYPHS = {
    {3'd0, 3'd2, 3'd0, 3'd2, 3'd0},
    {3'd7, 3'd4, 3'd7, 3'd5, 3'd7},
    {3'd7, 3'd5, 3'd7, 3'd5, 3'd7},
    {3'd4, 3'd4, 3'd4, 3'd4, 3'd7},
    {3'd7, 3'd5, 3'd7, 3'd1, 3'd7},
    {3'd7, 3'd4, 3'd7, 3'd1, 3'd7},
    {3'd4, 3'd4, 3'd7, 3'd5, 3'd5},
    {3'd7, 3'd4, 3'd7, 3'd4, 3'd7},
    {3'd7, 3'd1, 3'd7, 3'd4, 3'd7},
    {3'd7, 3'd2, 3'd2, 3'd3, 3'd2},
    {3'd7, 3'd5, 3'd5, 3'd5, 3'd7}
  };
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  x_q, x_d;
  logic [2:0]  y_q, y_d;
  logic [14:0] bitmap_q, bitmap_d;
  logic        valid_q, valid_d;
  logic [3:0]  number_q, number_d;
  logic        unknown_q, unknown_d;
  logic        accept, last_scan, last_drain;
  logic [4:0]  match;

  function automatic logic [4:0] decode(input logic [14:0] b);
    logic [4:0] r;
    r = 5'h1f;
    for (int i = 0; i < N_GLYPH; i++) if (b == GLYPHS[i]) r = {1'b0, 4'(i)};
    return r;
  endfunction

  assign busy = state_q == SCAN || state_q == DRAIN;

  always_comb begin
    accept = start && !busy;
    last_scan = state_q == SCAN && cnt_q == 5'd15;
    last_drain = state_q == DRAIN && cnt_q == 5'(15 + LIT_LATENCY);
    // the renderer answers LIT_LATENCY cycles late, so capture starts once the first answer arrives
    bitmap_d = busy && cnt_q > 5'(LIT_LATENCY) ? {lit, bitmap_q[14:1]} : bitmap_q;
    match = decode(bitmap_d);
    cnt_d = accept ? 5'd1 : busy ? cnt_q + 5'd1 : 5'd0;
    state_d = accept ? SCAN : last_scan ? DRAIN : last_drain ? MATCH : busy ? state_q : IDLE;
    x_d = state_q == SCAN && !last_scan ? (x_q == 2'd2 ? 2'd0 : x_q + 2'd1) : state_d == DRAIN ? x_q : 2'd0;
    y_d = state_q == SCAN && !last_scan ? (x_q == 2'd2 ? y_q + 3'd1 : y_q) : state_d == DRAIN ? y_q : 3'd0;
    valid_d = last_drain;
    number_d = last_drain ? match[3:0] : number_q;
    unknown_d = last_drain ? match[4] : unknown_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      bitmap_q <= '0;
      valid_q <= 1'b0;
      number_q <= '0;
      unknown_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      bitmap_q <= bitmap_d;
      valid_q <= valid_d;
      number_q <= number_d;
      unknown_q <= unknown_d;
    end
  end

  assign x_block = x_q;
  assign y_block = y_q;
  assign valid = valid_q;
  assign number = number_q;
  assign unknown = unknown_q;
endmodule

// File: tb/tb_digit_reader.sv
// tb_digit_reader: two reader+renderer lanes (LIT_LATENCY 1 and 3) with randomized scans,
// a string-table glyph model and a queue scoreboard. Honours DIGIT_READER_COLON_EN.
module tb_digit_reader;
  typedef struct {int cyc; int num; int unk;} exp_t;
`ifdef DIGIT_READER_COLON_EN
  localparam int N_KNOWN = 11;
`else
  localparam int N_KNOWN = 10;
`endif
  // glyphs as seen on screen, row-major, x fastest
  string glyph_s [11] = '{
    "####.##.##.####", ".#.##..#..#.###", "###..#####..###", "###..####..####",
    "#.##.####..#..#", "####..###..####", "####..####.####", "###..#..#..#..#",
    "####.#####.####", "####.####..####", "....#.....#...."
  };
  string blank_s = "...............";
  logic clk = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int lane, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s (L=%0d, cycle %0d): got %0d, expected %0d", name, lane, cyc, act, exp);
    end
  endtask

  function automatic bit rend(input int n, input bit f, input logic [1:0] xx, input logic [2:0] yy);
    int k;
    string r;
    k = int'(yy) * 3 + int'(xx);
    r = f ? blank_s : glyph_s[n];
    return k < 15 && r[k] == "#";
  endfunction

  function automatic int expect_num(input int n, input bit f);
    string r;
    r = f ? blank_s : glyph_s[n];
    for (int i = 0; i < N_KNOWN; i++) if (glyph_s[i] == r) return i;
    return 15;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int L = g == 0 ? 1 : 3;
    logic reset_n, start, lit, busy, valid, unknown;
    logic [1:0] x;
    logic [2:0] y;
    logic [3:0] number;
    logic [L-1:0] pipe = '0;
    int num = 0;
    bit force0 = 1'b0;
    exp_t q[$];
    int s = -1000;
    int last_num = 0;
    int last_unk = 0;

    digit_reader #(.LIT_LATENCY(L)) dut (
      .clk(clk), .reset(reset_n), .start(start), .x_block(x), .y_block(y),
      .lit(lit), .busy(busy), .valid(valid), .number(number), .unknown(unknown)
    );

    always @(posedge clk) pipe <= L'({pipe, rend(num, force0, x, y)});
    assign lit = pipe[L-1];

    always @(negedge clk) begin
      int k;
      exp_t e;
      k = cyc - s;
      chk("busy", L, int'(busy), int'(k >= 1 && k <= 15 + L));
      if (k >= 1 && k <= 15) begin
        chk("x_block", L, int'(x), (k - 1) % 3);
        chk("y_block", L, int'(y), (k - 1) / 3);
      end else if (k >= 16 && k <= 15 + L) begin
        chk("x_block drain", L, int'(x), 2);
        chk("y_block drain", L, int'(y), 4);
      end else if (k != 16 + L) begin
        chk("x_block idle", L, int'(x), 0);
        chk("y_block idle", L, int'(y), 0);
      end
      if (valid === 1'b1) begin
        if (q.size() == 0) chk("spurious valid", L, 1, 0);
        else begin
          e = q.pop_front();
          chk("valid cycle", L, cyc, e.cyc);
          chk("number", L, int'(number), e.num);
          chk("unknown", L, int'(unknown), e.unk);
          last_num = e.num;
          last_unk = e.unk;
        end
      end else begin
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          chk("missing valid", L, 0, 1);
          void'(q.pop_front());
        end
        chk("number held", L, int'(number), last_num);
        chk("unknown held", L, int'(unknown), last_unk);
      end
      if (!reset_n) begin
        q.delete();
        s = -1000;
        last_num = 0;
        last_unk = 0;
      end else if (start && !(k >= 1 && k <= 15 + L)) begin
        s = cyc;
        e.cyc = cyc + 16 + L;
        e.num = expect_num(num, force0);
        e.unk = int'(e.num == 15);
        q.push_back(e);
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic settle();
      for (int b = 0; b < 60 && q.size() != 0; b++) tick();
      chk("scan completion timeout", L, q.size(), 0);
    endtask

    initial begin
      reset_n = 1'b0;
      start = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      num = 7;
      start = 1'b1;
      tick();
      start = 1'b0;
      settle();
      // random glyphs with random extra start pulses, many landing while busy
      for (int r = 0; r < 8; r++) begin
        num = $urandom_range(0, 10);
        start = 1'b1;
        tick();
        for (int j = 0; j < 18 + L; j++) begin
          start = $urandom_range(0, 3) == 0;
          tick();
        end
        start = 1'b0;
        settle();
      end
      start = 1'b1;
      for (int d = 0; d < 10; d++) begin
        num = d;
        tick();
        repeat (15 + L) tick();
        if (d == 9) start = 1'b0;
      end
      settle();
      num = 10;
      start = 1'b1;
      tick();
      start = 1'b0;
      settle();
      force0 = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      settle();
      force0 = 1'b0;
      num = 3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      num = 5;
      start = 1'b1;
      tick();
      start = 1'b0;
      settle();
      repeat (3) tick();
      done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got %0d lanes done, expected 2", done_cnt);
    $fatal(1);
  end

  initial begin
    wait (done_cnt == 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/digit_reader.md
DIGIT_READER -- requirements
Module: digit_reader

Interface
REQ-001 SHALL have parameter LIT_LATENCY, default 1, meaning cycles from x_block/y_block change to the corresponding lit sample (legal 1..3).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request one glyph scan; sampled only while busy is low.
REQ-005 SHALL have port x_block  output  2  column address (0..2) driven to the digit renderer.
REQ-006 SHALL have port y_block  output  3  row address (0..4) driven to the digit renderer.
REQ-007 SHALL have port lit  input  1  renderer's block-on response for an earlier address.
REQ-008 SHALL have port busy  output  1  scan in progress.
REQ-009 SHALL have port valid  output  1  one-cycle pulse; number/unknown are valid in that cycle.
REQ-010 SHALL have port number  output  4  decoded glyph index (0-9 digits, 10 colon).
REQ-011 SHALL have port unknown  output  1  captured bitmap matched no table entry.

Function
REQ-012 SHALL decode the 3x5-block glyph produced by the digit renderer back to its index, i.e. act as the renderer's inverse.
REQ-013 SHALL implement FSM IDLE -> SCAN -> DRAIN -> MATCH -> IDLE; IDLE->SCAN on start high with busy low.
REQ-014 SCAN SHALL present the 15 addresses row-major, x fastest: (0,0),(1,0),(2,0),(0,1)..(2,4), one per cycle, in cycles 1..15 after the start cycle (cycle 0).
REQ-015 SHALL sample lit for the address presented in cycle k at cycle k+LIT_LATENCY into bitmap bit y*3+x (15-bit shift/capture register).
REQ-016 DRAIN SHALL last LIT_LATENCY cycles so the last sample lands at cycle 15+LIT_LATENCY; x_block/y_block SHALL hold (2,4) during DRAIN.
REQ-017 MATCH SHALL compare the 15-bit bitmap against the renderer's glyph table in one cycle; exact equality only.
REQ-018 valid SHALL pulse high for exactly one cycle at cycle 16+LIT_LATENCY; number/unknown SHALL be registered and hold until the next valid or reset.
REQ-019 On no match: unknown=1, number=4'hF; on match: unknown=0, number=index.
REQ-020 busy SHALL be high in cycles 1..15+LIT_LATENCY and low in the valid cycle; start in the valid cycle SHALL be accepted (back-to-back scans, no idle gap).
REQ-021 start while busy SHALL be ignored, not queued.
REQ-022 In IDLE, x_block/y_block SHALL be 0.

Reset
REQ-023 reset low at a clock edge SHALL force IDLE; busy=0, valid=0, number=0, unknown=0, x_block=0, y_block=0, bitmap=0.
REQ-024 reset mid-scan SHALL abort with no valid pulse; a start in the first cycle after reset release SHALL be accepted.

Configuration
REQ-025 Macro DIGIT_READER_COLON_EN defined: colon pattern included in the match table, decodes to number=10.
REQ-026 Macro not defined: table holds digits 0-9 only; colon pattern yields unknown=1, number=4'hF.

Verification
REQ-027 Bench SHALL connect digit_reader to the digit renderer (x_block/y_block -> renderer, renderer pixel -> lit) with matching LIT_LATENCY.
REQ-028 Renderer number=7, start pulse at cycle 0, LIT_LATENCY=1 -> address sequence (0,0)..(2,4) cycles 1..15, valid only at cycle 17, number=7, unknown=0.
REQ-029 Sweep renderer number 0..9 back-to-back, start held high -> ten valid pulses spaced 16+LIT_LATENCY cycles apart, number equal to each input, busy low only in valid cycles.
REQ-030 Renderer number=10: with DIGIT_READER_COLON_EN -> number=10, unknown=0; without -> number=4'hF, unknown=1.
REQ-031 Force lit=0 always -> unknown=1, number=4'hF; start pulse at cycle 5 (busy) ignored, only one valid.
REQ-032 reset low at cycle 8 of a scan -> no valid, all outputs 0 next cycle; new start at release -> correct result at 16+LIT_LATENCY cycles later; repeat with LIT_LATENCY=3 -> valid at cycle 19.
